ca_block_controller: RTL
========================

CA_BLOCK_CONTROLLER -- requirements
Module: ca_block_controller

Interface
REQ-001 The block SHALL have parameter NUM_BLOCKS, default 30, meaning the number of 8-cell blocks in the attached automaton (legal range 1..63).
REQ-002 The block SHALL have parameter ADDR_BITS, default 6, meaning the width of the block address bus.
REQ-003 The block SHALL have input clk, 1 bit, the clock; all logic is rising-edge.
REQ-004 The block SHALL have input reset, 1 bit, synchronous, active-high.
REQ-005 The block SHALL have inputs cmd_valid (1), cmd_op (2) and cmd_count (8), and output cmd_ready (1), forming the command channel.
REQ-006 The block SHALL have inputs ld_valid (1) and ld_data (8), and output ld_ready (1), forming the load stream, one beat per block, block 0 first.
REQ-007 The block SHALL have outputs dp_valid (1), dp_data (8) and dp_last (1), and input dp_ready (1), forming the dump stream, one beat per block, block 0 first.
REQ-008 The block SHALL have outputs ca_data_in (8), ca_we_n (1), ca_halt_n (1) and ca_addr (ADDR_BITS), all registered, which drive the automaton's data, write-enable, halt and address pins.
REQ-009 The block SHALL have input ca_data_out, 8 bits, which is the automaton's T+1 view of the addressed block.
REQ-010 The block SHALL have output busy, 1 bit, high whenever the FSM is not in IDLE.

Function
REQ-011 Opcodes SHALL be: 0 LOAD, 1 STEP, 2 DUMP, 3 NOP.
REQ-012 A command SHALL be accepted only on cmd_valid & cmd_ready; cmd_ready SHALL be high only in IDLE.
REQ-013 FSM states SHALL be IDLE, LOAD_WAIT, LOAD_WR, STEP, DUMP_SET, DUMP_CAP and DUMP_OUT; a NOP command or a STEP with cmd_count=0 SHALL return to IDLE on the next cycle.
REQ-014 In LOAD_WAIT, ld_ready SHALL be high; a handshake registers ld_data into ca_data_in and the block index into ca_addr, then moves to LOAD_WR.
REQ-015 In LOAD_WR, ca_we_n SHALL be low for exactly 1 cycle; the FSM then returns to LOAD_WAIT with index+1, or to IDLE after block NUM_BLOCKS-1.
REQ-016 In STEP, ca_halt_n SHALL be high for exactly cmd_count consecutive cycles, with ca_we_n held high, then drop low as the FSM enters IDLE.
REQ-017 In DUMP_SET, ca_addr SHALL be driven with the block index; DUMP_CAP (one cycle later) SHALL register ca_data_out into dp_data.
REQ-018 In DUMP_OUT, dp_valid SHALL be high; dp_data and dp_last SHALL stay stable until dp_ready; dp_last SHALL be high only on block NUM_BLOCKS-1.
REQ-019 DUMP SHALL return the automaton's T+1 view, one generation ahead of the stored state; the block SHALL NOT compensate for this.
REQ-020 ca_halt_n SHALL be low in every state other than STEP.
REQ-021 ca_we_n SHALL be high in every state other than LOAD_WR.
REQ-022 ca_addr SHALL never be driven to all-ones (the automaton treats all-ones as undriven).
REQ-023 The block index SHALL be an ADDR_BITS counter and SHALL clear to 0 on every command accept.
REQ-024 The step counter SHALL be 8 bits and SHALL count down with no wrap.

Reset
REQ-025 While reset is high, the block SHALL be in IDLE with cmd_ready=1 and ld_ready=0.
REQ-026 While reset is high, the dump outputs SHALL be dp_valid=0, dp_data=0 and dp_last=0.
REQ-027 While reset is high, the pin outputs SHALL be ca_we_n=1, ca_halt_n=0, ca_addr=0 and ca_data_in=0, and busy SHALL be 0.
REQ-028 Reset asserted mid-command SHALL abort the command within that cycle; a partial load or dump SHALL be discarded and not resumed.

Structure
REQ-029 Shared package ca_pkg SHALL hold the opcode enum, CELLS_PER_BLOCK=8, CA_ADDR_BITS=6 and CA_ADDR_UNDRIVEN=6'h3F.
REQ-030 The block SHALL contain no sub-module; the FSM, block index and step counter SHALL be inline.

Verification (bench with a 240-cell wrap-around rule-110 automaton model on the ca_* pins)
REQ-031 LOAD with block0=0x01 and other blocks 0x00, then DUMP: beat0=0x03, beats1..29=0x00, dp_last only on beat 29.
REQ-032 Same LOAD, then STEP count=1, then DUMP: beat0=0x07.
REQ-033 STEP count=5: ca_halt_n high for exactly 5 consecutive cycles; ca_we_n high throughout; busy low afterwards.
REQ-034 During DUMP, hold dp_ready low for 3 cycles on beat 2: dp_data is stable, no beat is dropped or duplicated, and 30 beats total.
REQ-035 Reset after the 4th LOAD beat, then a full LOAD of 0x00: all pins at reset values; a subsequent DUMP returns all 0x00.
REQ-036 Throughout every test: ca_addr is never 6'h3F, and ca_we_n low never coincides with ca_halt_n high.

Source files
------------

// File: rtl/ca_pkg.sv
// Shared definitions for the cellular-automaton block controller and its users.
package ca_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_STEP = 2'd1,
    OP_DUMP = 2'd2,
    OP_NOP  = 2'd3
  } ca_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_WAIT,
    S_LOAD_WR,
    S_STEP,
    S_DUMP_SET,
    S_DUMP_CAP,
    S_DUMP_OUT
  } ca_state_e;

  localparam int            CELLS_PER_BLOCK  = 8;
  localparam int            CA_ADDR_BITS     = 6;
  localparam logic [5:0]    CA_ADDR_UNDRIVEN = 6'h3F;

endpackage

// File: rtl/ca_block_controller.sv
// Sequences LOAD / STEP / DUMP commands onto the automaton's pin interface,
// streaming one 8-cell block per beat.
module ca_block_controller
  import ca_pkg::*;
#(
  parameter int NUM_BLOCKS = 30,
  parameter int ADDR_BITS  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  input  logic [1:0]           cmd_op,
  input  logic [7:0]           cmd_count,
  output logic                 cmd_ready,
  input  logic                 ld_valid,
  input  logic [7:0]           ld_data,
  output logic                 ld_ready,
  output logic                 dp_valid,
  output logic [7:0]           dp_data,
  output logic                 dp_last,
  input  logic                 dp_ready,
  output logic [7:0]           ca_data_in,
  output logic                 ca_we_n,
  output logic                 ca_halt_n,
  output logic [ADDR_BITS-1:0] ca_addr,
  input  logic [7:0]           ca_data_out,
  output logic                 busy
);

  localparam logic [ADDR_BITS-1:0] LAST_IDX = ADDR_BITS'(NUM_BLOCKS - 1);

  ca_state_e            state, state_n;
  logic [ADDR_BITS-1:0] idx;
  logic [7:0]           step_cnt;
  logic                 cmd_fire;

  // All-ones reads as "undriven" to the automaton, so never put it on the bus.
  function automatic logic [ADDR_BITS-1:0] safe_addr(input logic [ADDR_BITS-1:0] a);
    return (&a) ? '0 : a;
  endfunction

  assign cmd_fire = cmd_valid & cmd_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:
        if (cmd_valid) begin
          case (ca_op_e'(cmd_op))
            OP_LOAD: state_n = S_LOAD_WAIT;
            OP_STEP: state_n = (cmd_count != 8'd0) ? S_STEP : S_IDLE;
            OP_DUMP: state_n = S_DUMP_SET;
            default: state_n = S_IDLE;
          endcase
        end
      S_LOAD_WAIT: if (ld_valid) state_n = S_LOAD_WR;
      S_LOAD_WR:   state_n = (idx == LAST_IDX) ? S_IDLE : S_LOAD_WAIT;
      S_STEP:      state_n = (step_cnt <= 8'd1) ? S_IDLE : S_STEP;
      S_DUMP_SET:  state_n = S_DUMP_CAP;
      S_DUMP_CAP:  state_n = S_DUMP_OUT;
      S_DUMP_OUT:  if (dp_ready) state_n = dp_last ? S_IDLE : S_DUMP_SET;
      default:     state_n = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == S_IDLE) | reset;
    ld_ready  = (state == S_LOAD_WAIT) & ~reset;
    busy      = (state != S_IDLE) & ~reset;
  end

  // Pin strobes follow the next state so they line up exactly with the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx        <= '0;
      step_cnt   <= '0;
      ca_data_in <= '0;
      ca_we_n    <= 1'b1;
      ca_halt_n  <= 1'b0;
      ca_addr    <= '0;
      dp_valid   <= 1'b0;
      dp_data    <= '0;
      dp_last    <= 1'b0;
    end else begin
      ca_we_n   <= (state_n != S_LOAD_WR);
      ca_halt_n <= (state_n == S_STEP);
      case (state)
        S_IDLE:
          if (cmd_fire) begin
            idx      <= '0;
            step_cnt <= cmd_count;
            if (ca_op_e'(cmd_op) == OP_DUMP) ca_addr <= '0;
          end
        S_LOAD_WAIT:
          if (ld_valid) begin
            ca_data_in <= ld_data;
            ca_addr    <= safe_addr(idx);
          end
        S_LOAD_WR: idx <= idx + 1'b1;
        S_STEP:    if (step_cnt != 8'd0) step_cnt <= step_cnt - 1'b1;
        S_DUMP_CAP: begin
          dp_data  <= ca_data_out;
          dp_last  <= (idx == LAST_IDX);
          dp_valid <= 1'b1;
        end
        S_DUMP_OUT:
          if (dp_ready) begin
            dp_valid <= 1'b0;
            dp_last  <= 1'b0;
            if (!dp_last) begin
              idx     <= idx + 1'b1;
              ca_addr <= safe_addr(idx + 1'b1);
            end
          end
        default: ;
      endcase
    end
  end

endmodule
